// File: rtl/elev_pkg.sv
// Shared elevator constants and the call scheduler state encoding.
package elev_pkg;
    localparam int NUM_FLOORS = 51;
    localparam int FLOOR_W    = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        UP    = 2'd1,
        DOWN  = 2'd2,
        DWELL = 2'd3
    } state_t;
endpackage

// File: rtl/elev_floor_search.sv
// Nearest pending floor above and below the car, plus a hit on the car's own floor.
module elev_floor_search #(
    parameter int NUM_FLOORS = elev_pkg::NUM_FLOORS,
    parameter int FLOOR_W    = elev_pkg::FLOOR_W
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    cur_floor,
    output logic                  above_vld,
    output logic [FLOOR_W-1:0]    above_idx,
    output logic                  below_vld,
    output logic [FLOOR_W-1:0]    below_idx,
    output logic                  here
);

    logic [NUM_FLOORS-1:0] above_mask;
    logic [NUM_FLOORS-1:0] below_mask;

    always_comb begin
        above_mask = '0;
        below_mask = '0;
        here       = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            above_mask[i] = pending[i] && (FLOOR_W'(i) > cur_floor);
            below_mask[i] = pending[i] && (FLOOR_W'(i) < cur_floor);
            if (FLOOR_W'(i) == cur_floor) here = pending[i];
        end
    end

    // Descending scan leaves the lowest set bit; ascending scan leaves the highest.
    always_comb begin
        above_vld = 1'b0;
        above_idx = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (above_mask[i]) begin
                above_vld = 1'b1;
                above_idx = FLOOR_W'(i);
            end
        end
    end

    always_comb begin
        below_vld = 1'b0;
        below_idx = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (below_mask[i]) begin
                below_vld = 1'b1;
                below_idx = FLOOR_W'(i);
            end
        end
    end

endmodule

// File: rtl/elev_call_scheduler.sv
// SCAN call scheduler: latches calls, picks the next target, and times door dwell.
// state | meaning
// IDLE  | no direction, car holds at cur_floor
// UP    | serving calls above, req_floor tracks nearest one
// DOWN  | serving calls below, req_floor tracks nearest one
// DWELL | door open at a served floor, counting down
module elev_call_scheduler
    import elev_pkg::*;
#(
    parameter int NUM_FLOORS   = elev_pkg::NUM_FLOORS,
    parameter int FLOOR_W      = elev_pkg::FLOOR_W,
    parameter int DWELL_CYCLES = 8,
    parameter int CNT_W        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  call_valid,
    input  logic [FLOOR_W-1:0]    call_floor,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  stop,
    output logic [FLOOR_W-1:0]    req_floor,
    output logic                  dir_up,
    output logic                  dir_dwn,
    output logic                  dwell,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  call_err
);

    localparam logic [FLOOR_W-1:0] LAST_FLOOR = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [CNT_W-1:0]   DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

    state_t                  state, state_nxt;
    logic [FLOOR_W-1:0]      req_nxt;
    logic                    up_nxt, dn_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [NUM_FLOORS-1:0]   pend_nxt;
    logic                    above_vld, below_vld, here;
    logic [FLOOR_W-1:0]      above_idx, below_idx;
    logic                    call_ok, arrive, clr_en;

    elev_floor_search #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_search (
        .pending   (pending),
        .cur_floor (cur_floor),
        .above_vld (above_vld),
        .above_idx (above_idx),
        .below_vld (below_vld),
        .below_idx (below_idx),
        .here      (here)
    );

    assign call_ok = call_valid && (call_floor <= LAST_FLOOR);
    assign arrive  = stop && (cur_floor == req_floor);
    assign dwell   = (state == DWELL);

    always_comb begin
        state_nxt = state;
        req_nxt   = req_floor;
        up_nxt    = dir_up;
        dn_nxt    = dir_dwn;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                req_nxt = cur_floor;
                up_nxt  = 1'b0;
                dn_nxt  = 1'b0;
                if (here) begin
                    state_nxt = DWELL;
                    cnt_nxt   = DWELL_LOAD;
                end else if (above_vld) begin
                    state_nxt = UP;
                    up_nxt    = 1'b1;
                    req_nxt   = above_idx;
                end else if (below_vld) begin
                    state_nxt = DOWN;
                    dn_nxt    = 1'b1;
                    req_nxt   = below_idx;
                end
            end
            UP: begin
                if (arrive) begin
                    state_nxt = DWELL;
                    cnt_nxt   = DWELL_LOAD;
                    req_nxt   = cur_floor;
                end else if (above_vld) begin
                    req_nxt = above_idx;
                end else if (below_vld) begin
                    state_nxt = DOWN;
                    up_nxt    = 1'b0;
                    dn_nxt    = 1'b1;
                    req_nxt   = below_idx;
                end else begin
                    state_nxt = IDLE;
                    up_nxt    = 1'b0;
                    req_nxt   = cur_floor;
                end
            end
            DOWN: begin
                if (arrive) begin
                    state_nxt = DWELL;
                    cnt_nxt   = DWELL_LOAD;
                    req_nxt   = cur_floor;
                end else if (below_vld) begin
                    req_nxt = below_idx;
                end else if (above_vld) begin
                    state_nxt = UP;
                    up_nxt    = 1'b1;
                    dn_nxt    = 1'b0;
                    req_nxt   = above_idx;
                end else begin
                    state_nxt = IDLE;
                    dn_nxt    = 1'b0;
                    req_nxt   = cur_floor;
                end
            end
            DWELL: begin
                req_nxt = cur_floor;
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    // Keep the current sweep direction if it still has work, else reverse.
                    up_nxt    = 1'b0;
                    dn_nxt    = 1'b0;
                    state_nxt = IDLE;
                    if (dir_dwn ? below_vld : above_vld) begin
                        state_nxt = dir_dwn ? DOWN : UP;
                        dn_nxt    = dir_dwn;
                        up_nxt    = !dir_dwn;
                        req_nxt   = dir_dwn ? below_idx : above_idx;
                    end else if (dir_dwn ? above_vld : below_vld) begin
                        state_nxt = dir_dwn ? UP : DOWN;
                        dn_nxt    = !dir_dwn;
                        up_nxt    = dir_dwn;
                        req_nxt   = dir_dwn ? above_idx : below_idx;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A call to the car's own floor while the door is open is absorbed by the clear.
    assign clr_en = (state_nxt == DWELL);

    always_comb begin
        pend_nxt = pending;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (call_ok && (call_floor == FLOOR_W'(i))) pend_nxt[i] = 1'b1;
            if (clr_en && (cur_floor == FLOOR_W'(i)))  pend_nxt[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pending   <= '0;
            req_floor <= '0;
            dir_up    <= 1'b0;
            dir_dwn   <= 1'b0;
            cnt       <= '0;
            call_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            pending   <= pend_nxt;
            req_floor <= req_nxt;
            dir_up    <= up_nxt;
            dir_dwn   <= dn_nxt;
            cnt       <= cnt_nxt;
            call_err  <= call_valid && !call_ok;
        end
    end

endmodule

// File: tb/tb_elev_call_scheduler.sv
// Directed bench for elev_call_scheduler: vector table plus multi-cycle sequences.
module tb_elev_call_scheduler;
    localparam int NF = 51;
    localparam int FW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          call_valid = 1'b0;
    logic [FW-1:0] call_floor = '0;
    logic [FW-1:0] cur_floor = '0;
    logic          stop = 1'b0;
    logic [FW-1:0] req_floor;
    logic          dir_up, dir_dwn, dwell, call_err;
    logic [NF-1:0] pending;

    int n_pass = 0;
    int n_tot  = 0;

    elev_call_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .call_valid (call_valid),
        .call_floor (call_floor),
        .cur_floor  (cur_floor),
        .stop       (stop),
        .req_floor  (req_floor),
        .dir_up     (dir_up),
        .dir_dwn    (dir_dwn),
        .dwell      (dwell),
        .pending    (pending),
        .call_err   (call_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          cv;
        logic [FW-1:0] cf;
        logic [FW-1:0] cur;
        logic          stp;
        logic [FW-1:0] req;
        logic          up;
        logic          dn;
        logic          dw;
        logic          err;
        logic [NF-1:0] pend;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cv, input logic [FW-1:0] cf, input logic [FW-1:0] cur, input logic stp);
        call_valid = cv;
        call_floor = cf;
        cur_floor  = cur;
        stop       = stp;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, '0, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_dwell_end(output int cycles);
        cycles = 0;
        while (dwell && cycles < 30) begin
            tick();
            cycles++;
        end
    endtask

    int ncyc;

    initial begin
        vecs[0]  = '{1'b1, 6'd5,  6'd0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 51'd1 << 5};
        vecs[1]  = '{1'b0, 6'd0,  6'd0, 1'b0, 6'd5,  1'b1, 1'b0, 1'b0, 1'b0, 51'd1 << 5};
        vecs[2]  = '{1'b0, 6'd0,  6'd1, 1'b0, 6'd5,  1'b1, 1'b0, 1'b0, 1'b0, 51'd1 << 5};
        vecs[3]  = '{1'b0, 6'd0,  6'd5, 1'b1, 6'd5,  1'b1, 1'b0, 1'b1, 1'b0, 51'd0};
        for (int i = 4; i <= 10; i++)
            vecs[i] = '{1'b0, 6'd0, 6'd5, 1'b1, 6'd5, 1'b1, 1'b0, 1'b1, 1'b0, 51'd0};
        vecs[11] = '{1'b0, 6'd0,  6'd5, 1'b1, 6'd5,  1'b0, 1'b0, 1'b0, 1'b0, 51'd0};
        vecs[12] = '{1'b1, 6'd55, 6'd5, 1'b1, 6'd5,  1'b0, 1'b0, 1'b0, 1'b1, 51'd0};
        vecs[13] = '{1'b0, 6'd0,  6'd5, 1'b1, 6'd5,  1'b0, 1'b0, 1'b0, 1'b0, 51'd0};
        vecs[14] = '{1'b1, 6'd50, 6'd5, 1'b0, 6'd5,  1'b0, 1'b0, 1'b0, 1'b0, 51'd1 << 50};
        vecs[15] = '{1'b0, 6'd0,  6'd5, 1'b0, 6'd50, 1'b1, 1'b0, 1'b0, 1'b0, 51'd1 << 50};
        vecs[16] = '{1'b1, 6'd51, 6'd5, 1'b0, 6'd50, 1'b1, 1'b0, 1'b0, 1'b1, 51'd1 << 50};
        vecs[17] = '{1'b0, 6'd0,  6'd5, 1'b0, 6'd50, 1'b1, 1'b0, 1'b0, 1'b0, 51'd1 << 50};

        // Reset values
        do_reset();
        #1;
        chk("rst req",     64'(req_floor), 64'd0);
        chk("rst pending", 64'(pending),   64'd0);
        chk("rst outs",    64'({dir_up, dir_dwn, dwell, call_err}), 64'd0);

        // Basic call, dwell length, out-of-range calls, top floor
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].cv, vecs[i].cf, vecs[i].cur, vecs[i].stp);
            tick();
            chk($sformatf("v%0d req", i),  64'(req_floor), 64'(vecs[i].req));
            chk($sformatf("v%0d dirs", i), 64'({dir_up, dir_dwn}), 64'({vecs[i].up, vecs[i].dn}));
            chk($sformatf("v%0d dwell", i), 64'(dwell), 64'(vecs[i].dw));
            chk($sformatf("v%0d err", i),  64'(call_err), 64'(vecs[i].err));
            chk($sformatf("v%0d pend", i), 64'(pending), 64'(vecs[i].pend));
        end

        // Nearer call retargets mid-travel, then the sweep resumes
        do_reset();
        drive(1'b1, 6'd20, 6'd0, 1'b0); tick();
        drive(1'b0, 6'd0, 6'd0, 1'b0);  tick();
        chk("a req20", 64'(req_floor), 64'd20);
        drive(1'b1, 6'd10, 6'd3, 1'b0); tick();
        drive(1'b0, 6'd0, 6'd3, 1'b0);  tick();
        chk("a retarget", 64'(req_floor), 64'd10);
        drive(1'b0, 6'd0, 6'd10, 1'b1); tick();
        chk("a dwell10", 64'(dwell), 64'd1);
        chk("a pend20", 64'(pending), 64'(51'd1 << 20));
        wait_dwell_end(ncyc);
        chk("a dwell len", 64'(ncyc), 64'd8);
        chk("a resume", 64'({req_floor, dir_up}), 64'({6'd20, 1'b1}));

        // Call behind the car waits until the sweep finishes, then reverses
        do_reset();
        drive(1'b1, 6'd30, 6'd10, 1'b0); tick();
        drive(1'b0, 6'd0, 6'd10, 1'b0);  tick();
        drive(1'b1, 6'd4, 6'd15, 1'b0);  tick();
        drive(1'b0, 6'd0, 6'd15, 1'b0);  tick();
        chk("b keep30", 64'(req_floor), 64'd30);
        drive(1'b0, 6'd0, 6'd30, 1'b1);  tick();
        chk("b pend4", 64'(pending), 64'(51'd1 << 4));
        wait_dwell_end(ncyc);
        chk("b reverse", 64'({req_floor, dir_up, dir_dwn}), 64'({6'd4, 1'b0, 1'b1}));

        // Calls during dwell: own floor absorbed, other floor latched
        do_reset();
        drive(1'b1, 6'd7, 6'd7, 1'b1); tick();
        drive(1'b0, 6'd0, 6'd7, 1'b1); tick();
        chk("c dwell7", 64'({dwell, req_floor}), 64'({1'b1, 6'd7}));
        drive(1'b1, 6'd7, 6'd7, 1'b1);  tick();
        chk("c absorb7", 64'(pending), 64'd0);
        drive(1'b1, 6'd12, 6'd7, 1'b1); tick();
        chk("c latch12", 64'(pending), 64'(51'd1 << 12));
        drive(1'b0, 6'd0, 6'd7, 1'b1);
        wait_dwell_end(ncyc);
        chk("c rest len", 64'(ncyc), 64'd6);
        chk("c next12", 64'({req_floor, dir_up}), 64'({6'd12, 1'b1}));

        // Asynchronous reset mid-travel
        do_reset();
        drive(1'b1, 6'd15, 6'd0, 1'b0);  tick();
        drive(1'b1, 6'd40, 6'd0, 1'b0);  tick();
        drive(1'b0, 6'd0, 6'd20, 1'b0);  tick();
        chk("d req40", 64'(req_floor), 64'd40);
        #2 rst = 1'b0;
        #1;
        chk("d async", 64'({req_floor, dir_up, dir_dwn, dwell, call_err}), 64'd0);
        chk("d pend", 64'(pending), 64'd0);
        #1 rst = 1'b1;
        #1;
        chk("d release", 64'({req_floor, pending}), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
